fix_div_arb: RTL and testbench
==============================

Name: fix_div_arb

Overview:
- Shares one reciprocal-multiply divider datapath among N_REQ requesters. Each requester has its own programmable reciprocal coefficient, giving one divider per requester at the cost of one multiplier.
- Datapath: result = (din * recip) >> FRAC, truncated toward zero.
- Sits between the image-statistics / normalisation channels and a single 3-stage mxn multiplier.
- Arbitration is round-robin. Results are tagged with the requester id and buffered in a credit-protected result FIFO.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DW, 16, numerator and result width.
- RW, 16, reciprocal coefficient width.
- FRAC, 16, right-shift applied to the product (recip = 2^FRAC/denom).
- SIGNED, 0, 1 = signed numerator and coefficient, 0 = unsigned.
- FIFO_DEPTH, 8, result FIFO depth (power of 2, ≥ 5).

Ports:
- i_Sys_clk  in  1  clock.
- i_Rst  in  1  asynchronous active-high reset.
- i_En  in  1  0 = no new grants; in-flight operations still complete.
- i_Req_vld  in  N_REQ  per-requester request valid.
- i_Req_din  in  N_REQ*DW  numerators; requester k occupies bits [k*DW +: DW].
- o_Req_rdy  out  N_REQ  one-hot grant; a transfer occurs when vld&rdy.
- i_Recip  in  N_REQ*RW  per-requester coefficient; quasi-static.
- o_Res_vld  out  1  result FIFO not empty.
- o_Res_dout  out  DW  quotient.
- o_Res_id  out  clog2(N_REQ)  requester id of the result.
- i_Res_rdy  in  1  result consumer ready; pops the FIFO when vld&rdy.
- o_Busy  out  1  any operation in flight or FIFO not empty.

Behaviour:
- Reset (async, i_Rst=1) clears:
  - round-robin pointer → 0;
  - pipeline valid bits;
  - FIFO pointers and count;
  - credit counter → FIFO_DEPTH.
- Output reset values: o_Req_rdy=0, o_Res_vld=0, o_Res_dout=0, o_Res_id=0, o_Busy=0.
- Reset mid-operation drops all in-flight and buffered results; nothing is emitted afterwards.
- Credits:
  - credits = FIFO_DEPTH − fifo_count − inflight.
  - Accept decrements credits; FIFO pop increments them.
  - Accept and pop in the same cycle leave credits unchanged.
  - The FIFO never overflows.
- Grant:
  - o_Req_rdy is combinational from i_Req_vld, the pointer, credits and i_En.
  - At most one bit is set: the first valid requester at or after the pointer, wrapping.
  - No grant when credits=0 or i_En=0.
  - A requester must hold vld and din until its handshake completes.
- Pointer: after an accept from requester k, pointer ← (k+1) mod N_REQ. Unchanged when there is no accept.
- Pipeline, counting edges from the accept edge E0:
  - E0: register din, i_Recip[k] and id.
  - E1..E3: multiplier stages (3 cycles).
  - E4: rounding stage.
  - E5: FIFO write.
  - o_Res_vld is high after E5 when the FIFO was empty. Issue-to-result latency is 5 cycles.
- Throughput: one accept per cycle sustained while credits > 0 and i_Res_rdy=1.
- Arithmetic:
  - Product p is DW+RW bits, full precision, signed per SIGNED.
  - If p ≥ 0: q = p >> FRAC.
  - If p < 0: q = (p >>> FRAC) + 1 when the low FRAC bits are non-zero, otherwise p >>> FRAC (truncate toward zero).
  - Output is the low DW bits of q; there is no saturation. The caller sizes recip so the quotient fits.
- FIFO:
  - First-word-fall-through: o_Res_dout/o_Res_id are valid whenever o_Res_vld=1.
  - Simultaneous write and pop when full cannot occur (guaranteed by credits).
  - Simultaneous write and pop when empty: the write appears at the output the next cycle.
- Ordering: results leave in acceptance order across all requesters.
- i_Recip is sampled only at E0. Changing it affects only later accepts.
- i_En falling: no grant that cycle; the pipeline drains normally and o_Busy stays high until empty.

Optional Feature:
- Macro FIX_DIV_ARB_STAT_EN.
- Defined: adds output o_Stall_cnt [15:0].
  - Counts cycles with i_En=1, any i_Req_vld=1 and credits=0.
  - Saturates at 0xFFFF; reset to 0.
  - Cleared by a one-cycle pulse on added input i_Stall_clr; clear wins over a same-cycle increment.
- Undefined: neither port exists and no counter logic is built. Datapath and timing are identical in both builds.

Test Plan:
- Unsigned, single requester: Recip[0]=16384 (÷4), din=100, i_Res_rdy=1 → o_Res_vld 5 cycles after accept; dout=25, id=0.
- Approximation: Recip[1]=7281 (÷9), din=900 → dout=99. Documents truncation of the reciprocal.
- Round-robin: all 4 vld held, pointer=0 → grants 0,1,2,3,0 on consecutive cycles; results return in the same id order.
- Backpressure: i_Res_rdy=0, FIFO_DEPTH=8, continuous requests → exactly 8 accepts, then o_Req_rdy=0. Raising i_Res_rdy for 1 cycle allows exactly 1 further accept.
- Signed (SIGNED=1): Recip=7281, din=−900 → dout=−99; din=−16 with Recip=16384 → −4 (exact, no +1).
- Async reset asserted with 3 ops in flight and 2 in FIFO → all outputs 0 immediately; nothing emitted after release; first post-reset grant goes to requester 0.

Source files
------------

// File: rtl/fix_div_arb.sv
// Round-robin shared reciprocal-multiply divider: q = (din * recip) >> FRAC, truncated toward zero,
// with credit-protected FWFT result FIFO. Optional stall counter: define FIX_DIV_ARB_STAT_EN.
module fix_div_arb #(
  parameter int N_REQ      = 4,
  parameter int DW         = 16,
  parameter int RW         = 16,
  parameter int FRAC       = 16,
  parameter int SIGNED     = 0,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                       i_Sys_clk,
  input  logic                       i_Rst,
  input  logic                       i_En,
  input  logic [N_REQ-1:0]           i_Req_vld,
  input  logic [N_REQ*DW-1:0]        i_Req_din,
  output logic [N_REQ-1:0]           o_Req_rdy,
  input  logic [N_REQ*RW-1:0]        i_Recip,
  output logic                       o_Res_vld,
  output logic [DW-1:0]              o_Res_dout,
  output logic [$clog2(N_REQ)-1:0]   o_Res_id,
  input  logic                       i_Res_rdy,
  output logic                       o_Busy
`ifdef FIX_DIV_ARB_STAT_EN
  ,
  input  logic                       i_Stall_clr,
  output logic [15:0]                o_Stall_cnt
`endif
);

  localparam int   IDW = $clog2(N_REQ);
  localparam int   PW  = DW + RW;
  localparam int   AW  = $clog2(FIFO_DEPTH);
  localparam int   CW  = $clog2(FIFO_DEPTH + 1);
  localparam int   EW  = DW + IDW;
  localparam logic SGN = (SIGNED != 0);

  // Negative products shift arithmetically, then step back toward zero if any fraction bit was set.
  function automatic logic [DW-1:0] f_quot(input logic signed [PW-1:0] p);
    logic        [PW-1:0] mask;
    logic signed [PW-1:0] sh;
    logic        [PW-1:0] q;
    mask = (PW'(1) << FRAC) - PW'(1);
    if (SGN && p[PW-1]) begin
      sh = p >>> FRAC;
      q  = sh + PW'(|(p & mask));
    end else begin
      q  = p >> FRAC;
    end
    return q[DW-1:0];
  endfunction

  logic [DW-1:0]        w_din_arr [N_REQ];
  logic [RW-1:0]        w_rc_arr  [N_REQ];
  logic [N_REQ-1:0]     w_gnt;
  logic [IDW-1:0]       w_gnt_id;
  logic                 w_found;
  logic                 w_acc;
  logic                 w_pop;
  logic [IDW-1:0]       r_ptr;
  logic [CW-1:0]        r_credits;

  logic                 r_vld_p0, r_vld_p1, r_vld_p2, r_vld_p3, r_vld_p4;
  logic [DW-1:0]        r_din_p0;
  logic [RW-1:0]        r_rc_p0;
  logic [IDW-1:0]       r_id_p0, r_id_p1, r_id_p2, r_id_p3, r_id_p4;
  logic signed [PW-1:0] w_a_ext, w_b_ext;
  logic signed [PW-1:0] r_prod_p1, r_prod_p2, r_prod_p3;
  logic [DW-1:0]        r_q_p4;

  logic [EW-1:0]        r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wptr, r_rptr;
  logic [CW-1:0]        r_cnt;
  logic [EW-1:0]        w_head;

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign w_din_arr[g] = i_Req_din[g*DW +: DW];
    assign w_rc_arr[g]  = i_Recip[g*RW +: RW];
  end

  always_comb begin
    logic [IDW:0] s;
    logic [IDW-1:0] j;
    w_gnt    = '0;
    w_gnt_id = '0;
    w_found  = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      s = {1'b0, r_ptr} + (IDW+1)'(i);
      if (s >= (IDW+1)'(N_REQ)) s = s - (IDW+1)'(N_REQ);
      j = s[IDW-1:0];
      if (!w_found && i_Req_vld[j]) begin
        w_found  = 1'b1;
        w_gnt[j] = 1'b1;
        w_gnt_id = j;
      end
    end
    if (!i_En || (r_credits == '0) || i_Rst) w_gnt = '0;
  end

  assign o_Req_rdy = w_gnt;
  assign w_acc     = |w_gnt;
  assign w_pop     = o_Res_vld && i_Res_rdy;

  always_ff @(posedge i_Sys_clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_ptr     <= '0;
      r_credits <= CW'(FIFO_DEPTH);
    end else begin
      if (w_acc) r_ptr <= (w_gnt_id == IDW'(N_REQ - 1)) ? '0 : w_gnt_id + 1'b1;
      if (w_acc && !w_pop)      r_credits <= r_credits - 1'b1;
      else if (!w_acc && w_pop) r_credits <= r_credits + 1'b1;
    end
  end

  always_ff @(posedge i_Sys_clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_vld_p0 <= 1'b0;
      r_vld_p1 <= 1'b0;
      r_vld_p2 <= 1'b0;
      r_vld_p3 <= 1'b0;
      r_vld_p4 <= 1'b0;
    end else begin
      r_vld_p0 <= w_acc;
      r_vld_p1 <= r_vld_p0;
      r_vld_p2 <= r_vld_p1;
      r_vld_p3 <= r_vld_p2;
      r_vld_p4 <= r_vld_p3;
    end
  end

  // p0: capture operands of the granted requester
  always_ff @(posedge i_Sys_clk) begin
    if (w_acc) begin
      r_din_p0 <= w_din_arr[w_gnt_id];
      r_rc_p0  <= w_rc_arr[w_gnt_id];
      r_id_p0  <= w_gnt_id;
    end
  end

  assign w_a_ext = {{RW{r_din_p0[DW-1] & SGN}}, r_din_p0};
  assign w_b_ext = {{DW{r_rc_p0[RW-1] & SGN}}, r_rc_p0};

  // p1..p3: full-precision product, two retiming registers behind it
  always_ff @(posedge i_Sys_clk) begin
    r_prod_p1 <= w_a_ext * w_b_ext;
    r_prod_p2 <= r_prod_p1;
    r_prod_p3 <= r_prod_p2;
    r_id_p1   <= r_id_p0;
    r_id_p2   <= r_id_p1;
    r_id_p3   <= r_id_p2;
  end

  // p4: shift and truncate toward zero
  always_ff @(posedge i_Sys_clk) begin
    r_q_p4  <= f_quot(r_prod_p3);
    r_id_p4 <= r_id_p3;
  end

  // FIFO write one edge after p4; credits guarantee space
  always_ff @(posedge i_Sys_clk) begin
    if (r_vld_p4) r_mem[r_wptr] <= {r_id_p4, r_q_p4};
  end

  always_ff @(posedge i_Sys_clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (r_vld_p4) r_wptr <= r_wptr + 1'b1;
      if (w_pop)    r_rptr <= r_rptr + 1'b1;
      if (r_vld_p4 && !w_pop)      r_cnt <= r_cnt + 1'b1;
      else if (!r_vld_p4 && w_pop) r_cnt <= r_cnt - 1'b1;
    end
  end

  assign w_head     = r_mem[r_rptr];
  assign o_Res_vld  = (r_cnt != '0);
  assign o_Res_dout = o_Res_vld ? w_head[DW-1:0] : '0;
  assign o_Res_id   = o_Res_vld ? w_head[EW-1:DW] : '0;
  assign o_Busy     = r_vld_p0 | r_vld_p1 | r_vld_p2 | r_vld_p3 | r_vld_p4 | o_Res_vld;

`ifdef FIX_DIV_ARB_STAT_EN
  logic w_stall;
  logic [15:0] r_stall_cnt;

  assign w_stall = i_En && (|i_Req_vld) && (r_credits == '0);

  always_ff @(posedge i_Sys_clk or posedge i_Rst) begin
    if (i_Rst)                                    r_stall_cnt <= '0;
    else if (i_Stall_clr)                         r_stall_cnt <= '0;
    else if (w_stall && (r_stall_cnt != 16'hFFFF)) r_stall_cnt <= r_stall_cnt + 1'b1;
  end

  assign o_Stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_fix_div_arb.sv
// Scoreboard bench: unsigned 4-requester instance plus a signed 2-requester instance.
module tb_fix_div_arb;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en;
  logic [3:0]  vld, rdy;
  logic [63:0] din, recip;
  logic        res_vld, res_rdy, busy;
  logic [15:0] res_dout;
  logic [1:0]  res_id;

  logic [1:0]  s_vld, s_rdy;
  logic [31:0] s_din, s_recip;
  logic        s_res_vld, s_res_rdy, s_busy;
  logic [15:0] s_res_dout;
  logic [0:0]  s_res_id;

`ifdef FIX_DIV_ARB_STAT_EN
  logic        stall_clr = 1'b0;
  logic [15:0] stall_cnt, s_stall_cnt;
`endif

  fix_div_arb #(.N_REQ(4), .DW(16), .RW(16), .FRAC(16), .SIGNED(0), .FIFO_DEPTH(8)) u_dut (
    .i_Sys_clk(clk), .i_Rst(rst), .i_En(en),
    .i_Req_vld(vld), .i_Req_din(din), .o_Req_rdy(rdy), .i_Recip(recip),
    .o_Res_vld(res_vld), .o_Res_dout(res_dout), .o_Res_id(res_id),
    .i_Res_rdy(res_rdy), .o_Busy(busy)
`ifdef FIX_DIV_ARB_STAT_EN
    , .i_Stall_clr(stall_clr), .o_Stall_cnt(stall_cnt)
`endif
  );

  fix_div_arb #(.N_REQ(2), .DW(16), .RW(16), .FRAC(16), .SIGNED(1), .FIFO_DEPTH(8)) u_sdut (
    .i_Sys_clk(clk), .i_Rst(rst), .i_En(en),
    .i_Req_vld(s_vld), .i_Req_din(s_din), .o_Req_rdy(s_rdy), .i_Recip(s_recip),
    .o_Res_vld(s_res_vld), .o_Res_dout(s_res_dout), .o_Res_id(s_res_id),
    .i_Res_rdy(s_res_rdy), .o_Busy(s_busy)
`ifdef FIX_DIV_ARB_STAT_EN
    , .i_Stall_clr(stall_clr), .o_Stall_cnt(s_stall_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;
  logic [17:0] exp_q[$];
  logic [16:0] s_exp_q[$];
  logic [17:0] m_e;
  logic [16:0] s_m_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitors: pop one expectation per delivered result
  always @(negedge clk) begin
    if (!rst && res_vld && res_rdy) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL res_unexpected actual=%0h required=none", {res_id, res_dout});
      end else begin
        m_e = exp_q.pop_front();
        check("res", 32'({res_id, res_dout}), 32'(m_e));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && s_res_vld && s_res_rdy) begin
      if (s_exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL sres_unexpected actual=%0h required=none", {s_res_id, s_res_dout});
      end else begin
        s_m_e = s_exp_q.pop_front();
        check("sres", 32'({s_res_id, s_res_dout}), 32'(s_m_e));
      end
    end
  end

  task automatic issue(input int k, input logic [15:0] d, input logic [15:0] e);
    int n;
    vld[k] = 1'b1;
    din[k*16 +: 16] = d;
    n = 0;
    while (n < 50) begin
      @(negedge clk);
      if (rdy[k]) break;
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL issue_timeout actual=no_grant required=grant k=%0d", k);
    end else begin
      exp_q.push_back({2'(k), e});
    end
    @(posedge clk); #1;
    vld[k] = 1'b0;
  endtask

  task automatic s_issue(input int k, input logic [15:0] d, input logic [15:0] e);
    int n;
    s_vld[k] = 1'b1;
    s_din[k*16 +: 16] = d;
    n = 0;
    while (n < 50) begin
      @(negedge clk);
      if (s_rdy[k]) break;
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL sissue_timeout actual=no_grant required=grant k=%0d", k);
    end else begin
      s_exp_q.push_back({1'(k), e});
    end
    @(posedge clk); #1;
    s_vld[k] = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((busy || s_busy) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_busy", 32'(busy), 32'd0);
    check("drain_sbusy", 32'(s_busy), 32'd0);
  endtask

  initial begin
    int n, acc, vc;
    logic [15:0] rr_exp [4];
    rst = 1'b1; en = 1'b1; vld = 4'hF; din = '0; res_rdy = 1'b1;
    recip = {16'd13107, 16'd21845, 16'd7281, 16'd16384};
    s_vld = '0; s_din = '0; s_res_rdy = 1'b1;
    s_recip = {16'd7281, 16'd16384};
    repeat (2) @(posedge clk);
    #1;
    check("rst_rdy", 32'(rdy), 32'd0);
    check("rst_res_vld", 32'(res_vld), 32'd0);
    check("rst_dout", 32'(res_dout), 32'd0);
    check("rst_id", 32'(res_id), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    vld = 4'h0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Single requester, latency
    issue(0, 16'd100, 16'd25);
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      if (res_vld) break;
      @(posedge clk);
      n++;
    end
    check("latency", 32'(n), 32'd5);
    drain();

    issue(1, 16'd900, 16'd99);
    issue(0, 16'hFFFF, 16'h3FFF);
    issue(3, 16'd50, 16'd9);
    drain();

    // Signed instance
    s_issue(1, 16'hFC7C, 16'hFF9D);
    s_issue(0, 16'hFFF0, 16'hFFFC);
    s_issue(0, 16'hFFEF, 16'hFFFC);
    s_issue(0, 16'hFFFF, 16'h0000);
    s_issue(0, 16'd100, 16'd25);
    drain();

    // Round robin, pointer at 0 after requester 3
    din = {16'd500, 16'd30, 16'd90, 16'd400};
    rr_exp[0] = 16'd100; rr_exp[1] = 16'd9; rr_exp[2] = 16'd9; rr_exp[3] = 16'd99;
    vld = 4'hF;
    for (int g = 0; g < 5; g++) begin
      @(negedge clk);
      check("rr_gnt", 32'(rdy), 32'(1) << (g % 4));
      exp_q.push_back({2'(g % 4), rr_exp[g % 4]});
      @(posedge clk); #1;
    end
    vld = 4'h0;
    drain();

    // Backpressure: credits stop grants at FIFO_DEPTH
    res_rdy = 1'b0;
    din[15:0] = 16'd400;
    vld = 4'b0001;
    acc = 0;
    repeat (20) begin
      @(negedge clk);
      if (rdy[0]) begin acc++; exp_q.push_back({2'd0, 16'd100}); end
      @(posedge clk); #1;
    end
    check("bp_accepts", 32'(acc), 32'd8);
    @(negedge clk);
    check("bp_rdy", 32'(rdy), 32'd0);
    @(posedge clk); #1;
    res_rdy = 1'b1;
    @(posedge clk); #1;
    res_rdy = 1'b0;
    acc = 0;
    repeat (10) begin
      @(negedge clk);
      if (rdy[0]) begin acc++; exp_q.push_back({2'd0, 16'd100}); end
      @(posedge clk); #1;
    end
    check("bp_extra", 32'(acc), 32'd1);
    vld = 4'h0;
    res_rdy = 1'b1;
    drain();

    // Reset with 3 in flight and 2 buffered
    res_rdy = 1'b0;
    vld = 4'b0001;
    acc = 0; n = 0;
    while (acc < 5 && n < 20) begin
      @(negedge clk);
      if (rdy[0]) begin acc++; exp_q.push_back({2'd0, 16'd100}); end
      @(posedge clk); #1;
      n++;
    end
    vld = 4'h0;
    check("mid_accepts", 32'(acc), 32'd5);
    @(posedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    check("pre_rst_vld", 32'(res_vld), 32'd1);
    check("pre_rst_dout", 32'(res_dout), 32'd100);
    #2;
    rst = 1'b1;
    vld = 4'hF;
    #1;
    exp_q.delete();
    check("arst_rdy", 32'(rdy), 32'd0);
    check("arst_vld", 32'(res_vld), 32'd0);
    check("arst_dout", 32'(res_dout), 32'd0);
    check("arst_id", 32'(res_id), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    vld = 4'h0;
    @(posedge clk); #1;
    rst = 1'b0;
    res_rdy = 1'b1;
    vc = 0;
    repeat (20) begin
      @(negedge clk);
      if (res_vld) vc++;
    end
    check("post_rst_silent", 32'(vc), 32'd0);
    @(posedge clk); #1;
    vld = 4'hF;
    @(negedge clk);
    check("post_rst_gnt", 32'(rdy), 32'd1);
    exp_q.push_back({2'd0, 16'd100});
    @(posedge clk); #1;
    vld = 4'h0;
    drain();

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    check("ssb_empty", 32'(s_exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
